// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch stage and its pipeline register.
package cpu_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE = 6'b111111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Case-equality: x/z in the opcode field never counts as a match.
    function automatic logic is_opcode(input logic [INST_W-1:0] inst,
                                       input logic [OPCODE_W-1:0] op);
        return (inst[INST_W-1 -: OPCODE_W] === op);
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Address/data link between the fetch stage (master) and the combinational instruction memory (slave).
interface instruction_fetch_if;
    import cpu_pkg::*;

    logic [ADDR_W-1:0] inst_add;
    logic [INST_W-1:0] inst;

    modport master (output inst_add, input inst);
    modport slave  (input inst_add, output inst);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid, load captures, otherwise holds.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_flush,
    input  logic [INST_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc
);

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_inst  <= i_inst;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_inst  = r_inst;
    assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, run/halt control, and IF/ID capture with stall and redirect.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]   RESET_PC    = 32'd0,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE,
    parameter int unsigned         IMEM_DEPTH  = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    instruction_fetch_if.master imem,
    input  logic                id_stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                if_id_valid,
    output logic [INST_W-1:0]   if_id_inst,
    output logic [ADDR_W-1:0]   if_id_pc,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    // The memory aliases addresses itself; the PC is never masked here.
    if (IMEM_DEPTH == 0) begin : g_depth_check
        $error("IMEM_DEPTH must be nonzero");
    end

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_fetch_count;
    logic              r_halted;

    logic              w_halt_hit;
    logic              w_load;
    logic              w_flush;
    logic [INST_W-1:0] w_cap_inst;

    assign imem.inst_add = r_pc;
    assign w_halt_hit    = is_opcode(imem.inst, HALT_OPCODE);

    always_comb begin
        w_load     = 1'b0;
        w_flush    = 1'b0;
        w_cap_inst = w_halt_hit ? {HALT_OPCODE, {(INST_W-OPCODE_W){1'b0}}} : imem.inst;
        case (r_state)
            RUN: begin
                if (redirect_valid)  w_flush = 1'b1;
                else if (!id_stall)  w_load  = 1'b1;
            end
            HALTED: w_flush = !id_stall;
            default: w_flush = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (!id_stall) begin
                        r_fetch_count <= r_fetch_count + 32'd1;
                        if (w_halt_hit) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= r_pc + 32'd1;
                        end
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_inst  (w_cap_inst),
        .i_pc    (r_pc),
        .o_valid (if_id_valid),
        .o_inst  (if_id_inst),
        .o_pc    (if_id_pc)
    );

    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
